gelato_warp_pc_sched: RTL and testbench

Per-warp PC table and round-robin fetch scheduler for the Gelato frontend. It holds one PC and one state per warp, accepts warp launches and next-PC updates from the back end, and each cycle offers one ready warp's PC to the instruction fetch unit over a valid/ready handshake. It is the master side of the PC-table-to-ifetch link.

---
 rtl/gelato_pkg.sv | 29 ++
 rtl/gelato_rr_arbiter.sv | 40 ++++
 rtl/gelato_warp_pc_sched.sv | 148 ++++++++++++++
 tb/tb_gelato_warp_pc_sched.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gelato_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gelato_pkg
//  Purpose  : Shared types and default sizes for the Gelato frontend PC table
//             and fetch scheduler.
//  Contents : warp_state_t  per-warp lifecycle state (IDLE/READY/WAIT)
//             NUM_WARPS_DEF, PC_WIDTH_DEF  default table geometry
//             wid_t, pc_t   warp-id / PC types at the default geometry
//  Revision : 1.0  initial release
// ============================================================================
package gelato_pkg;

  localparam int NUM_WARPS_DEF = 8;
  localparam int PC_WIDTH_DEF  = 32;

  // IDLE  : slot free, may be launched
  // READY : PC valid, eligible for fetch arbitration
  // WAIT  : PC handed to ifetch, waiting for the back end's next-PC update
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    WAIT  = 2'd2
  } warp_state_t;

  typedef logic [$clog2(NUM_WARPS_DEF)-1:0] wid_t;
  typedef logic [PC_WIDTH_DEF-1:0]          pc_t;

endpackage
`default_nettype wire

// File: rtl/gelato_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : gelato_rr_arbiter
//  Purpose  : Combinational round-robin pick. Searches the request mask
//             starting at last_grant+1 and wrapping; the first set bit wins.
//  Ports    : req        [NUM_REQ]    request mask
//             last_grant [IDX_WIDTH]  index granted most recently
//             grant      [IDX_WIDTH]  winning index (0 when nothing requests)
//             any_grant               at least one request present
//  Revision : 1.0  initial release
// ============================================================================
module gelato_rr_arbiter #(
  parameter int NUM_REQ   = 8,
  parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] last_grant,
  output logic [IDX_WIDTH-1:0] grant,
  output logic                 any_grant
);

  logic [IDX_WIDTH-1:0] w_idx;

  // NUM_REQ is a power of two, so the index addition wraps naturally.
  // Offset NUM_REQ lands back on last_grant, giving it lowest priority.
  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    w_idx     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = last_grant + IDX_WIDTH'(i);
      if (!any_grant && req[w_idx]) begin
        grant     = w_idx;
        any_grant = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gelato_warp_pc_sched.sv
`default_nettype none
// ============================================================================
//  Module   : gelato_warp_pc_sched
//  Purpose  : Per-warp PC table with round-robin fetch scheduling. Accepts
//             warp launches and next-PC updates, offers one READY warp's PC
//             per cycle to instruction fetch over valid/ready (master side of
//             the PC-table-to-ifetch link; ifetch_* are the master modport
//             signals of gelato_pctable_ifetch_if).
//  Ports    : clk, rst (sync, active-high), rdy (global issue enable)
//             launch_valid/launch_wid/launch_pc, launch_ready (slot IDLE)
//             upd_valid/upd_wid/upd_pc/upd_exit  next-PC return path
//             ifetch_valid/ifetch_ready/ifetch_wid/ifetch_pc  fetch offer
//             active_mask (bit i = warp i not IDLE), err (sticky)
//  Config   : GELATO_PCTABLE_ERR_EN  when defined, err latches on ignored
//             updates and on launches to busy slots; otherwise err is 0.
//  Revision : 1.0  initial release
// ============================================================================
module gelato_warp_pc_sched
  import gelato_pkg::*;
#(
  parameter int NUM_WARPS = NUM_WARPS_DEF,
  parameter int PC_WIDTH  = PC_WIDTH_DEF,
  parameter int WID_WIDTH = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 launch_valid,
  input  logic [WID_WIDTH-1:0] launch_wid,
  input  logic [PC_WIDTH-1:0]  launch_pc,
  output logic                 launch_ready,
  input  logic                 upd_valid,
  input  logic [WID_WIDTH-1:0] upd_wid,
  input  logic [PC_WIDTH-1:0]  upd_pc,
  input  logic                 upd_exit,
  output logic                 ifetch_valid,
  input  logic                 ifetch_ready,
  output logic [WID_WIDTH-1:0] ifetch_wid,
  output logic [PC_WIDTH-1:0]  ifetch_pc,
  output logic [NUM_WARPS-1:0] active_mask,
  output logic                 err
);

  localparam logic [WID_WIDTH-1:0] c_last_grant_init = WID_WIDTH'(NUM_WARPS - 1);

  warp_state_t          r_state [NUM_WARPS];
  logic [PC_WIDTH-1:0]  r_pc    [NUM_WARPS];
  logic [WID_WIDTH-1:0] r_last_grant;
  logic                 r_lock;
  logic [WID_WIDTH-1:0] r_lock_wid;

  logic [NUM_WARPS-1:0] w_req;
  logic [WID_WIDTH-1:0] w_arb_grant;
  logic                 w_arb_any;
  logic [WID_WIDTH-1:0] w_wid;
  logic                 w_valid;
  logic                 w_hs;
  logic                 w_launch_acc;
  logic                 w_upd_acc;

  for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_slot
    assign w_req[gi]       = (r_state[gi] == READY);
    assign active_mask[gi] = (r_state[gi] != IDLE);
  end

  gelato_rr_arbiter #(
    .NUM_REQ   (NUM_WARPS),
    .IDX_WIDTH (WID_WIDTH)
  ) u_arb (
    .req        (w_req),
    .last_grant (r_last_grant),
    .grant      (w_arb_grant),
    .any_grant  (w_arb_any)
  );

  // A locked warp stays READY until its handshake, and a READY warp's PC
  // cannot change (launch needs IDLE, update needs WAIT), so holding the
  // warp id alone keeps both ifetch_wid and ifetch_pc stable.
  assign w_wid        = r_lock ? r_lock_wid : w_arb_grant;
  assign w_valid      = rdy && (r_lock || w_arb_any);
  assign w_hs         = w_valid && ifetch_ready;

  assign ifetch_valid = w_valid;
  assign ifetch_wid   = w_wid;
  assign ifetch_pc    = r_pc[w_wid];

  assign launch_ready = (r_state[launch_wid] == IDLE);
  assign w_launch_acc = launch_valid && launch_ready;
  // An update for the warp being handshaked this cycle sees READY, not WAIT,
  // so it is ignored by this same check.
  assign w_upd_acc    = upd_valid && (r_state[upd_wid] == WAIT);

  // Launch, update and handshake each require a different current state,
  // so at most one of them can touch any given slot in a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        r_state[i] <= IDLE;
        r_pc[i]    <= '0;
      end
      r_last_grant <= c_last_grant_init;
      r_lock       <= 1'b0;
      r_lock_wid   <= '0;
    end else begin
      if (w_launch_acc) begin
        r_state[launch_wid] <= READY;
        r_pc[launch_wid]    <= launch_pc;
      end
      if (w_upd_acc) begin
        if (upd_exit) begin
          r_state[upd_wid] <= IDLE;
        end else begin
          r_state[upd_wid] <= READY;
          r_pc[upd_wid]    <= upd_pc;
        end
      end
      if (w_hs) begin
        r_state[w_wid] <= WAIT;
        r_last_grant   <= w_wid;
      end
      // With rdy low nothing is offered, so the lock is simply held.
      if (rdy) begin
        r_lock <= w_valid && !ifetch_ready;
        if (w_valid) begin
          r_lock_wid <= w_wid;
        end
      end
    end
  end

`ifdef GELATO_PCTABLE_ERR_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((launch_valid && !launch_ready) || (upd_valid && !w_upd_acc)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gelato_warp_pc_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gelato_warp_pc_sched
//  Purpose  : Self-checking bench for gelato_warp_pc_sched. Directed scenarios
//             followed by randomized traffic, compared each cycle against a
//             behavioural model of the warp table and round-robin policy.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gelato_warp_pc_sched;

  localparam int NW = 8;
  localparam int PW = 32;
  localparam int WW = 3;

  localparam int ST_IDLE  = 0;
  localparam int ST_READY = 1;
  localparam int ST_WAIT  = 2;

`ifdef GELATO_PCTABLE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          rdy;
  logic          launch_valid;
  logic [WW-1:0] launch_wid;
  logic [PW-1:0] launch_pc;
  logic          launch_ready;
  logic          upd_valid;
  logic [WW-1:0] upd_wid;
  logic [PW-1:0] upd_pc;
  logic          upd_exit;
  logic          ifetch_valid;
  logic          ifetch_ready;
  logic [WW-1:0] ifetch_wid;
  logic [PW-1:0] ifetch_pc;
  logic [NW-1:0] active_mask;
  logic          err;

  always #5 clk = ~clk;

  gelato_warp_pc_sched #(
    .NUM_WARPS (NW),
    .PC_WIDTH  (PW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .launch_valid (launch_valid),
    .launch_wid   (launch_wid),
    .launch_pc    (launch_pc),
    .launch_ready (launch_ready),
    .upd_valid    (upd_valid),
    .upd_wid      (upd_wid),
    .upd_pc       (upd_pc),
    .upd_exit     (upd_exit),
    .ifetch_valid (ifetch_valid),
    .ifetch_ready (ifetch_ready),
    .ifetch_wid   (ifetch_wid),
    .ifetch_pc    (ifetch_pc),
    .active_mask  (active_mask),
    .err          (err)
  );

  // ---------------- behavioural model ----------------
  int            m_state [NW];
  logic [PW-1:0] m_pc    [NW];
  int            m_last;
  bit            m_lock;
  int            m_lock_wid;
  bit            m_err;
  bit            e_valid;
  int            e_wid;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NW; i++) begin
      m_state[i] = ST_IDLE;
      m_pc[i]    = '0;
    end
    m_last     = NW - 1;
    m_lock     = 1'b0;
    m_lock_wid = 0;
    m_err      = 1'b0;
  endfunction

  // Which warp should be on offer right now, given the current inputs.
  function automatic void model_offer();
    bit found;
    found   = 1'b0;
    e_valid = 1'b0;
    e_wid   = 0;
    if (m_lock) begin
      e_wid   = m_lock_wid;
      e_valid = rdy;
    end else begin
      for (int k = 1; k <= NW; k++) begin
        int w;
        w = (m_last + k) % NW;
        if (!found && m_state[w] == ST_READY) begin
          found   = 1'b1;
          e_wid   = w;
          e_valid = rdy;
        end
      end
    end
  endfunction

  function automatic void model_update();
    bit hs, lacc, uacc;
    if (rst) begin
      model_reset();
      return;
    end
    model_offer();
    hs   = e_valid && ifetch_ready;
    lacc = launch_valid && (m_state[launch_wid] == ST_IDLE);
    uacc = upd_valid && (m_state[upd_wid] == ST_WAIT);
    if (ERR_EN && ((launch_valid && !lacc) || (upd_valid && !uacc))) m_err = 1'b1;
    if (rdy) begin
      m_lock = e_valid && !ifetch_ready;
      if (e_valid) m_lock_wid = e_wid;
    end
    if (hs) begin
      m_state[e_wid] = ST_WAIT;
      m_last         = e_wid;
    end
    if (lacc) begin
      m_state[launch_wid] = ST_READY;
      m_pc[launch_wid]    = launch_pc;
    end
    if (uacc) begin
      if (upd_exit) m_state[upd_wid] = ST_IDLE;
      else begin
        m_state[upd_wid] = ST_READY;
        m_pc[upd_wid]    = upd_pc;
      end
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    rst          = 1'b0;
    rdy          = 1'b1;
    launch_valid = 1'b0;
    launch_wid   = '0;
    launch_pc    = '0;
    upd_valid    = 1'b0;
    upd_wid      = '0;
    upd_pc       = '0;
    upd_exit     = 1'b0;
    ifetch_ready = 1'b0;
  endtask

  // Let inputs settle, then compare every output against the model.
  task automatic settle();
    logic [NW-1:0] exp_mask;
    #1;
    model_offer();
    for (int i = 0; i < NW; i++) exp_mask[i] = (m_state[i] != ST_IDLE);
    chk("ifetch_valid", ifetch_valid, e_valid);
    if (e_valid) begin
      chk("ifetch_wid", ifetch_wid, e_wid);
      chk("ifetch_pc", ifetch_pc, m_pc[e_wid]);
    end
    chk("active_mask", active_mask, exp_mask);
    chk("launch_ready", launch_ready, m_state[launch_wid] == ST_IDLE);
    chk("err", err, m_err);
  endtask

  task automatic clock();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    clock();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    @(negedge clk);

    // Reset state (rst still asserted)
    settle();
    chk("rst_valid", ifetch_valid, 1'b0);
    chk("rst_wid", ifetch_wid, 3'd0);
    chk("rst_pc", ifetch_pc, 32'h0);
    chk("rst_mask", active_mask, 8'h00);
    chk("rst_err", err, 1'b0);
    clock();

    // Launch warp 3, offered next cycle, then fetched
    idle_inputs();
    launch_valid = 1'b1; launch_wid = 3'd3; launch_pc = 32'h100;
    step();
    idle_inputs();
    ifetch_ready = 1'b1;
    settle();
    chk("t1_valid", ifetch_valid, 1'b1);
    chk("t1_wid", ifetch_wid, 3'd3);
    chk("t1_pc", ifetch_pc, 32'h100);
    clock();
    idle_inputs();
    settle();
    chk("t1_mask", active_mask, 8'h08);
    chk("t1_idle", ifetch_valid, 1'b0);
    clock();
    upd_valid = 1'b1; upd_wid = 3'd3; upd_exit = 1'b1;
    step();

    // Launch 0,1,2 then stream grants with immediate updates
    for (int w = 0; w < 3; w++) begin
      idle_inputs();
      launch_valid = 1'b1; launch_wid = WW'(w); launch_pc = PW'(w * 'h40);
      step();
    end
    for (int k = 0; k < 6; k++) begin
      idle_inputs();
      ifetch_ready = 1'b1;
      if (k > 0) begin
        upd_valid = 1'b1;
        upd_wid   = WW'((k - 1) % 3);
        upd_pc    = PW'(((k - 1) % 3) * 'h40);
      end
      settle();
      chk("t2_grant", ifetch_wid, WW'(k % 3));
      chk("t2_valid", ifetch_valid, 1'b1);
      clock();
    end

    // Fetch warp 0, then hold an offer of warp 1 while warp 0 returns
    idle_inputs();
    ifetch_ready = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      idle_inputs();
      if (k == 1) begin
        upd_valid = 1'b1; upd_wid = 3'd0; upd_pc = 32'h0;
      end
      settle();
      chk("t3_hold_wid", ifetch_wid, 3'd1);
      chk("t3_hold_pc", ifetch_pc, 32'h40);
      clock();
    end
    idle_inputs();
    ifetch_ready = 1'b1;
    settle();
    chk("t3_accept_wid", ifetch_wid, 3'd1);
    clock();

    // Warp 2 exits
    idle_inputs();
    upd_valid = 1'b1; upd_wid = 3'd2; upd_exit = 1'b1;
    step();
    idle_inputs();
    launch_wid = 3'd2;
    settle();
    chk("t4_launch_ready", launch_ready, 1'b1);
    chk("t4_mask_bit2", active_mask[2], 1'b0);
    chk("t4_err_clean", err, 1'b0);
    clock();

    // Ignored update to IDLE warp 5, rejected launch to busy warp 0
    idle_inputs();
    upd_valid = 1'b1; upd_wid = 3'd5; upd_pc = 32'hdead;
    step();
    idle_inputs();
    launch_valid = 1'b1; launch_wid = 3'd0; launch_pc = 32'h999;
    settle();
    chk("t5_launch_ready", launch_ready, 1'b0);
    clock();
    idle_inputs();
    settle();
    chk("t5_err", err, ERR_EN);
    chk("t5_mask", active_mask[5], 1'b0);
    clock();

    // rdy low: no offers, launches still land
    for (int k = 0; k < 3; k++) begin
      idle_inputs();
      rdy = 1'b0; ifetch_ready = 1'b1;
      if (k == 0) begin
        launch_valid = 1'b1; launch_wid = 3'd6; launch_pc = 32'h600;
      end
      settle();
      chk("t6_rdy_low", ifetch_valid, 1'b0);
      clock();
    end
    idle_inputs();
    settle();
    chk("t6_mask_bit6", active_mask[6], 1'b1);
    clock();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      idle_inputs();
      rst          = ($urandom_range(0, 79) == 0);
      rdy          = ($urandom_range(0, 5) != 0);
      ifetch_ready = ($urandom_range(0, 2) != 0);
      launch_valid = ($urandom_range(0, 2) == 0);
      launch_wid   = WW'($urandom_range(0, NW - 1));
      launch_pc    = PW'($urandom) & ~32'h3;
      upd_valid    = ($urandom_range(0, 1) == 0);
      upd_wid      = WW'($urandom_range(0, NW - 1));
      for (int t = 0; t < 4; t++) begin
        if (m_state[upd_wid] != ST_WAIT) upd_wid = WW'($urandom_range(0, NW - 1));
      end
      upd_pc   = PW'($urandom) & ~32'h3;
      upd_exit = ($urandom_range(0, 3) == 0);
      step();
    end

    // Reset pulse in the middle of traffic
    idle_inputs();
    for (int w = 0; w < 4; w++) begin
      launch_valid = 1'b1; launch_wid = WW'(w + 4); launch_pc = PW'(w * 'h10 + 'h200);
      step();
    end
    idle_inputs();
    rst = 1'b1; ifetch_ready = 1'b1;
    launch_valid = 1'b1; launch_wid = 3'd1; launch_pc = 32'h1234;
    step();
    idle_inputs();
    settle();
    chk("rst2_valid", ifetch_valid, 1'b0);
    chk("rst2_wid", ifetch_wid, 3'd0);
    chk("rst2_pc", ifetch_pc, 32'h0);
    chk("rst2_mask", active_mask, 8'h00);
    chk("rst2_err", err, 1'b0);
    clock();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
